// File: rtl/escrita_registradores_pkg.sv
// Shared definitions for the register-bank write side: sizes, PC index, reset value,
// the write-entry record and the 3-to-8 address decoder.
package escrita_registradores_pkg;

  localparam int       LARGURA_PADRAO = 16;
  localparam int       NUM_REGS       = 8;
  localparam int       VALOR_RESET    = 0;
  localparam logic [2:0] ENDERECO_PC  = 3'd7;

  typedef struct packed {
    logic [2:0]                endereco;
    logic [LARGURA_PADRAO-1:0] dado;
  } entrada_t;

  function automatic logic [NUM_REGS-1:0] decodifica_3x8(input logic [2:0] endereco);
    logic [NUM_REGS-1:0] v;
    v = '0;
    v[endereco] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/escrita_registradores_fila.sv
// Synchronous FIFO buffering write requests; push is ignored when full, pop when empty.
// Depth must be a power of two so the pointers wrap naturally.
module fila_escrita #(
  parameter int LARGURA      = 19,
  parameter int PROFUNDIDADE = 2
) (
  input  logic                                  clock,
  input  logic                                  resetn,
  input  logic                                  push,
  input  logic                                  pop,
  input  logic [LARGURA-1:0]                    dado_entrada,
  output logic [LARGURA-1:0]                    dado_saida,
  output logic                                  cheio,
  output logic                                  vazio,
  output logic [$clog2(PROFUNDIDADE+1)-1:0]     count
);

  localparam int PTR_W = $clog2(PROFUNDIDADE);
  localparam int CNT_W = $clog2(PROFUNDIDADE+1);

  logic [LARGURA-1:0] mem [PROFUNDIDADE];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic               push_ef;
  logic               pop_ef;

  assign cheio      = (count == CNT_W'(PROFUNDIDADE));
  assign vazio      = (count == '0);
  assign push_ef    = push & ~cheio;
  assign pop_ef     = pop & ~vazio;
  assign dado_saida = mem[head];

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clock) begin
    if (push_ef) mem[tail] <= dado_entrada;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ef) tail <= tail + 1'b1;
      if (pop_ef)  head <= head + 1'b1;
      if (push_ef && !pop_ef)      count <= count + 1'b1;
      else if (pop_ef && !push_ef) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/escrita_registradores.sv
// Write side of the register bank: valid/ready request FIFO draining one entry per cycle
// into eight registers; R7 is the program counter with a single-cycle increment.
module escrita_registradores
  import escrita_registradores_pkg::*;
#(
  parameter int LARGURA      = LARGURA_PADRAO,
  parameter int PROFUNDIDADE = 2
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               wr_valido,
  output logic               wr_pronto,
  input  logic [2:0]         wr_endereco,
  input  logic [LARGURA-1:0] wr_dado,
  input  logic               incr_pc,
  output logic               ocupado,
  output logic [LARGURA-1:0] registrador0,
  output logic [LARGURA-1:0] registrador1,
  output logic [LARGURA-1:0] registrador2,
  output logic [LARGURA-1:0] registrador3,
  output logic [LARGURA-1:0] registrador4,
  output logic [LARGURA-1:0] registrador5,
  output logic [LARGURA-1:0] registrador6,
  output logic [LARGURA-1:0] registrador7
);

  localparam int LARG_ENTRADA = LARGURA + 3;
  localparam int CNT_W        = $clog2(PROFUNDIDADE+1);

  logic [LARG_ENTRADA-1:0] entrada;
  logic [LARG_ENTRADA-1:0] cabeca;
  logic [2:0]              cab_endereco;
  logic [LARGURA-1:0]      cab_dado;
  logic                    cheio;
  logic                    vazio;
  logic [CNT_W-1:0]        count;
  logic [NUM_REGS-1:0]     habilita;
  logic [LARGURA-1:0]      regs [NUM_REGS];
  logic [LARGURA-1:0]      prox [NUM_REGS];

  assign entrada      = {wr_endereco, wr_dado};
  assign cab_endereco = cabeca[LARG_ENTRADA-1 -: 3];
  assign cab_dado     = cabeca[LARGURA-1:0];
  assign wr_pronto    = ~cheio;
  assign ocupado      = ~vazio;

  fila_escrita #(
    .LARGURA      (LARG_ENTRADA),
    .PROFUNDIDADE (PROFUNDIDADE)
  ) u_fila (
    .clock        (clock),
    .resetn       (resetn),
    .push         (wr_valido & wr_pronto),
    .pop          (~vazio),
    .dado_entrada (entrada),
    .dado_saida   (cabeca),
    .cheio        (cheio),
    .vazio        (vazio),
    .count        (count)
  );

  assign habilita = vazio ? '0 : decodifica_3x8(cab_endereco);

  // R7 priority: FIFO write, then increment, then hold.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      prox[i] = regs[i];
      if (habilita[i]) prox[i] = cab_dado;
    end
    if (!habilita[ENDERECO_PC] && incr_pc)
      prox[ENDERECO_PC] = regs[ENDERECO_PC] + 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= LARGURA'(VALOR_RESET);
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= prox[i];
    end
  end

  assign registrador0 = regs[0];
  assign registrador1 = regs[1];
  assign registrador2 = regs[2];
  assign registrador3 = regs[3];
  assign registrador4 = regs[4];
  assign registrador5 = regs[5];
  assign registrador6 = regs[6];
  assign registrador7 = regs[7];

endmodule
